// File: rtl/lvl_buffer_controller_if.sv
// Handshake bundle between upstream dispatcher, level buffer and downstream consumer.
// The controller takes the slave modport; the driving side takes master.
interface lvl_buffer_controller_if;
    logic [15:0] lvl_data;
    logic [31:0] limits_data;
    logic        in_valid;
    logic        iter_ready;
    logic [15:0] out_lvl;
    logic [15:0] out_upper;
    logic [15:0] out_lower;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output lvl_data, limits_data, in_valid, out_ready,
        input  iter_ready, out_lvl, out_upper, out_lower, out_valid
    );

    modport slave (
        input  lvl_data, limits_data, in_valid, out_ready,
        output iter_ready, out_lvl, out_upper, out_lower, out_valid
    );
endinterface

// File: rtl/lvl_buffer_controller.sv
// First-word fall-through buffer for level samples with their limits, with skid-based
// issue permission, drop accounting and a sticky range check on accepted entries.
module lvl_buffer_controller #(
    parameter int DEPTH = 16,
    parameter int SKID  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_clear,
    lvl_buffer_controller_if.slave     bus,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow,
    output logic [15:0]                o_drop_cnt,
    output logic                       o_range_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // iter_ready is (DEPTH - count_next) > SKID, rewritten as a compare against a constant.
    localparam logic [CW-1:0] ITER_LIM = CW'(DEPTH - SKID);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [47:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_iter_ready;
    logic          r_overflow;
    logic [15:0]   r_drop_cnt;
    logic          r_range_err;

    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_range_bad;
    logic [CW-1:0] w_count_next;
    logic [47:0]   w_head;
    logic signed [15:0] w_lvl;
    logic signed [15:0] w_upper;
    logic signed [15:0] w_lower;

    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = !i_clear && (r_count != '0) && bus.out_ready;
    assign w_push  = !i_clear && bus.in_valid && (!w_full || w_pop);
    assign w_drop  = !i_clear && bus.in_valid && w_full && !w_pop;

    assign w_lvl   = $signed(bus.lvl_data);
    assign w_upper = $signed(bus.limits_data[31:16]);
    assign w_lower = $signed(bus.limits_data[15:0]);
    assign w_range_bad = (w_lvl < w_lower) || (w_lvl > w_upper);

    always_comb begin
        w_count_next = r_count;
        if (i_clear) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - CW'(1);
        end
    end

    // Storage carries no reset: contents are meaningless while the buffer is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {bus.limits_data, bus.lvl_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_iter_ready <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_cnt   <= '0;
            r_range_err  <= 1'b0;
        end else begin
            r_count      <= w_count_next;
            r_iter_ready <= (w_count_next < ITER_LIM);
            if (i_clear) begin
                r_wptr      <= '0;
                r_rptr      <= '0;
                r_overflow  <= 1'b0;
                r_drop_cnt  <= '0;
                r_range_err <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + AW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + AW'(1);
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                    if (r_drop_cnt != 16'hFFFF) begin
                        r_drop_cnt <= r_drop_cnt + 16'd1;
                    end
                end
                if (w_push && w_range_bad) begin
                    r_range_err <= 1'b1;
                end
            end
        end
    end

    assign w_head         = r_mem[r_rptr];
    assign bus.out_lvl    = w_head[15:0];
    assign bus.out_lower  = w_head[31:16];
    assign bus.out_upper  = w_head[47:32];
    assign bus.out_valid  = (r_count != '0);
    assign bus.iter_ready = r_iter_ready;

    assign o_count     = r_count;
    assign o_overflow  = r_overflow;
    assign o_drop_cnt  = r_drop_cnt;
    assign o_range_err = r_range_err;
endmodule

// File: tb/tb_lvl_buffer_controller.sv
// Randomized and directed bench for lvl_buffer_controller against a queue-based model.
module tb_lvl_buffer_controller;
    localparam int DEPTH = 16;
    localparam int SKID  = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic [CW-1:0] count;
    logic          overflow;
    logic [15:0]   drop_cnt;
    logic          range_err;

    lvl_buffer_controller_if bus ();

    lvl_buffer_controller #(.DEPTH(DEPTH), .SKID(SKID)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (clear),
        .bus         (bus.slave),
        .o_count     (count),
        .o_overflow  (overflow),
        .o_drop_cnt  (drop_cnt),
        .o_range_err (range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a plain queue of {upper, lower, lvl} entries plus status flags.
    logic [47:0] m_q[$];
    bit          m_iter;
    bit          m_ovf;
    int          m_drops;
    bit          m_rerr;

    function automatic void model_reset();
        m_q.delete();
        m_iter  = 1'b0;
        m_ovf   = 1'b0;
        m_drops = 0;
        m_rerr  = 1'b0;
    endfunction

    always @(posedge clk) begin
        if (rst_n) begin
            if (clear) begin
                m_q.delete();
                m_ovf   = 1'b0;
                m_drops = 0;
                m_rerr  = 1'b0;
            end else begin
                bit pop;
                bit full;
                pop  = (m_q.size() != 0) && bus.out_ready;
                full = (m_q.size() == DEPTH);
                if (pop) void'(m_q.pop_front());
                if (bus.in_valid) begin
                    if (!full || pop) begin
                        m_q.push_back({bus.limits_data, bus.lvl_data});
                        if ($signed(bus.lvl_data) < $signed(bus.limits_data[15:0]) ||
                            $signed(bus.lvl_data) > $signed(bus.limits_data[31:16]))
                            m_rerr = 1'b1;
                    end else begin
                        m_ovf = 1'b1;
                        if (m_drops < 65535) m_drops++;
                    end
                end
            end
            m_iter = (DEPTH - m_q.size()) > SKID;
        end
    end

    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("count",     32'(count),         32'(m_q.size()));
            chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
            chk("iter_rdy",  32'(bus.iter_ready), 32'(m_iter));
            chk("overflow",  32'(overflow),      32'(m_ovf));
            chk("drop_cnt",  32'(drop_cnt),      32'(m_drops));
            chk("range_err", 32'(range_err),     32'(m_rerr));
            if (m_q.size() != 0) begin
                chk("out_lvl",   32'(bus.out_lvl),   32'(m_q[0][15:0]));
                chk("out_lower", 32'(bus.out_lower), 32'(m_q[0][31:16]));
                chk("out_upper", 32'(bus.out_upper), 32'(m_q[0][47:32]));
            end
        end
    end

    // Drive inputs for one cycle; returns at the next falling edge with post-edge outputs.
    task automatic cyc(input bit v, input logic [15:0] l, input logic [15:0] u,
                       input logic [15:0] lo, input bit rdy, input bit clr);
        bus.in_valid    = v;
        bus.lvl_data    = l;
        bus.limits_data = {u, lo};
        bus.out_ready   = rdy;
        clear           = clr;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    logic [15:0] got[$];

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.lvl_data = '0;
        bus.limits_data = '0;
        bus.out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_iter",  32'(bus.iter_ready), 32'd0);
        chk("rst_flags", {29'd0, overflow, range_err, 1'b0}, 32'd0);
        chk("rst_drops", 32'(drop_cnt), 32'd0);
        cmp_en = 1'b1;
        rst_n = 1'b1;
        idle();
        chk("iter_after_rst", 32'(bus.iter_ready), 32'd1);

        // Single entry
        cyc(1'b1, 16'd5, 16'd10, 16'hFFFD, 1'b0, 1'b0);
        chk("single_valid", 32'(bus.out_valid), 32'd1);
        chk("single_lvl",   32'(bus.out_lvl),   32'd5);
        chk("single_upper", 32'(bus.out_upper), 32'd10);
        chk("single_lower", 32'(bus.out_lower), 32'h0000FFFD);
        chk("single_count", 32'(count), 32'd1);
        chk("single_rerr",  32'(range_err), 32'd0);
        cyc(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);

        // Fill to full, then one dropped entry
        for (int k = 1; k <= 17; k++) begin
            cyc(1'b1, 16'(100 + k), 16'h7FFF, 16'h8000, 1'b0, 1'b0);
            if (k == 13) chk("fill_iter13", 32'(bus.iter_ready), 32'd1);
            if (k == 14) chk("fill_iter14", 32'(bus.iter_ready), 32'd0);
        end
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_ovf",   32'(overflow), 32'd1);
        chk("fill_drops", 32'(drop_cnt), 32'd1);

        // Full with simultaneous push and pop
        cyc(1'b1, 16'h0ABC, 16'h7FFF, 16'h8000, 1'b1, 1'b0);
        chk("sim_count", 32'(count), 32'd16);
        chk("sim_drops", 32'(drop_cnt), 32'd1);
        for (int k = 0; k < 15; k++) cyc(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("sim_marker", 32'(bus.out_lvl), 32'h0ABC);
        chk("sim_left",   32'(count), 32'd1);
        cyc(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);

        // Range violation, then clear with a concurrent push and pop request
        cyc(1'b1, 16'd12, 16'd10, 16'd0, 1'b0, 1'b0);
        chk("range_set", 32'(range_err), 32'd1);
        cyc(1'b1, 16'd3, 16'd10, 16'd0, 1'b1, 1'b1);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_rerr",  32'(range_err), 32'd0);
        chk("clr_ovf",   32'(overflow), 32'd0);
        chk("clr_drops", 32'(drop_cnt), 32'd0);

        // Wrap-around stream of 40 entries, issue gated by iter_ready
        begin
            int sent;
            bit rdy;
            sent = 0;
            rdy = 1'b1;
            got.delete();
            for (int c = 0; c < 400 && (sent < 40 || count != 0); c++) begin
                bit v;
                v = (sent < 40) && bus.iter_ready;
                if (bus.out_valid && rdy) got.push_back(bus.out_lvl);
                cyc(v, 16'(1000 + sent), 16'h7FFF, 16'h8000, rdy, 1'b0);
                if (v) sent++;
                rdy = ~rdy;
            end
            chk("wrap_drops", 32'(drop_cnt), 32'd0);
            chk("wrap_len",   32'(got.size()), 32'd40);
            for (int i = 0; i < got.size() && i < 40; i++)
                chk("wrap_order", 32'(got[i]), 32'(1000 + i));
        end

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int l, u, lo;
            l  = int'($urandom_range(40)) - 20;
            u  = int'($urandom_range(30)) - 5;
            lo = int'($urandom_range(30)) - 25;
            cyc($urandom_range(99) < 70, l[15:0], u[15:0], lo[15:0],
                $urandom_range(99) < 45, $urandom_range(99) < 2);
        end

        // Asynchronous reset with entries held
        cyc(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
        for (int k = 0; k < 7; k++) cyc(1'b1, 16'(k), 16'd100, 16'd0, 1'b0, 1'b0);
        chk("ar_count7", 32'(count), 32'd7);
        idle();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("ar_valid", 32'(bus.out_valid), 32'd0);
        chk("ar_iter",  32'(bus.iter_ready), 32'd0);
        chk("ar_count", 32'(count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        chk("ar_iter_rel", 32'(bus.iter_ready), 32'd1);
        chk("ar_count_rel", 32'(count), 32'd0);

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
